multi_clock_divider: RTL and testbench



---
 rtl/multi_clock_divider.sv | 144 ++++++++++++++
 tb/tb_multi_clock_divider.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_clock_divider.sv
// Runtime-programmable multi-channel clock divider with per-channel period/high-time and tick strobe.
// Optional `SYNC_RESTART_EN adds sync_in, which force-wraps every enabled channel for phase alignment.
module multi_clock_divider #(
    parameter  int NUM_CH         = 4,
    parameter  int CNT_W          = 32,
    parameter  int DEFAULT_PERIOD = 2,
    parameter  int DEFAULT_HIGH   = 1,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SYNC_RESTART_EN
    input  logic              sync_in,
`endif
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_period,
    input  logic [CNT_W-1:0]  wr_high,
    output logic              wr_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam int unsigned NCH_U    = NUM_CH;
    localparam int unsigned CH_SLOTS = 2 ** CH_W;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t ONE   = cnt_t'(1);
    localparam cnt_t DEF_P = cnt_t'(DEFAULT_PERIOD);
    localparam cnt_t DEF_H = cnt_t'(DEFAULT_HIGH);

    cnt_t per_q [NUM_CH];
    cnt_t high_q[NUM_CH];
    cnt_t shp_q [NUM_CH];
    cnt_t shh_q [NUM_CH];
    cnt_t cnt_q [NUM_CH];
    logic [NUM_CH-1:0] pend_q;

    cnt_t per_d [NUM_CH];
    cnt_t high_d[NUM_CH];
    cnt_t shp_d [NUM_CH];
    cnt_t shh_d [NUM_CH];
    cnt_t cnt_d [NUM_CH];
    logic [NUM_CH-1:0] pend_d;
    logic [NUM_CH-1:0] clk_d;
    logic [NUM_CH-1:0] tick_d;

    logic [CH_SLOTS-1:0] ch_valid;
    logic                wr_ok;
    logic                sync_w;

`ifdef SYNC_RESTART_EN
    assign sync_w = sync_in;
`else
    assign sync_w = 1'b0;
`endif

    // Lookup of legal channel indices; avoids a compare that is constant when NUM_CH is a power of two
    always_comb begin
        ch_valid = '0;
        for (int unsigned i = 0; i < CH_SLOTS; i++) begin
            ch_valid[i] = (i < NCH_U);
        end
    end

    assign wr_ok = wr_en && ch_valid[wr_ch] && (wr_period != '0);

    always_comb begin
        pend_d = pend_q;
        clk_d  = '0;
        tick_d = '0;
        for (int unsigned c = 0; c < NCH_U; c++) begin
            per_d[c]  = per_q[c];
            high_d[c] = high_q[c];
            shp_d[c]  = shp_q[c];
            shh_d[c]  = shh_q[c];
            cnt_d[c]  = cnt_q[c];
            if (ch_en[c]) begin
                if ((cnt_q[c] == per_q[c] - ONE) || sync_w) begin
                    if (pend_q[c]) begin
                        per_d[c]  = shp_q[c];
                        high_d[c] = shh_q[c];
                        pend_d[c] = 1'b0;
                    end
                    cnt_d[c]  = '0;
                    tick_d[c] = 1'b1;
                end else begin
                    cnt_d[c] = cnt_q[c] + ONE;
                end
                clk_d[c] = (cnt_d[c] < high_d[c]);
                // A write landing on a wrap is only shadowed here, so it waits for the following wrap
                if (wr_ok && (wr_ch == CH_W'(c))) begin
                    shp_d[c]  = wr_period;
                    shh_d[c]  = wr_high;
                    pend_d[c] = 1'b1;
                end
            end else begin
                if (wr_ok && (wr_ch == CH_W'(c))) begin
                    per_d[c]  = wr_period;
                    high_d[c] = wr_high;
                    shp_d[c]  = wr_period;
                    shh_d[c]  = wr_high;
                    pend_d[c] = 1'b0;
                end else if (pend_q[c]) begin
                    per_d[c]  = shp_q[c];
                    high_d[c] = shh_q[c];
                    pend_d[c] = 1'b0;
                end
                cnt_d[c] = per_d[c] - ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned c = 0; c < NCH_U; c++) begin
                per_q[c]  <= DEF_P;
                high_q[c] <= DEF_H;
                shp_q[c]  <= DEF_P;
                shh_q[c]  <= DEF_H;
                cnt_q[c]  <= DEF_P - ONE;
            end
            pend_q  <= '0;
            clk_out <= '0;
            tick    <= '0;
            wr_err  <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < NCH_U; c++) begin
                per_q[c]  <= per_d[c];
                high_q[c] <= high_d[c];
                shp_q[c]  <= shp_d[c];
                shh_q[c]  <= shh_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
            pend_q  <= pend_d;
            clk_out <= clk_d;
            tick    <= tick_d;
            wr_err  <= wr_en && !wr_ok;
        end
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed self-checking bench for multi_clock_divider (NUM_CH=5 so an out-of-range channel is encodable).
module tb_multi_clock_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ch_en;
    logic       wr_en;
    logic [2:0] wr_ch;
    logic [7:0] wr_period;
    logic [7:0] wr_high;
    logic       wr_err;
    logic [4:0] clk_out;
    logic [4:0] tick;
`ifdef SYNC_RESTART_EN
    logic       sync_in;
`endif

    int passed = 0;
    int total  = 0;

    int c1_clk [11] = '{1,1,0,0,1,1,1,0,0,0,1};
    int c1_tick[11] = '{1,0,0,0,1,0,0,0,0,0,1};
    int c2_clk [16] = '{1,1,0,0,0,1,1,1,0,0,0,1,1,0,0,1};
    int c2_tick[16] = '{0,0,0,0,0,1,0,0,0,0,0,1,0,0,0,1};

    multi_clock_divider #(
        .NUM_CH(5),
        .CNT_W(8),
        .DEFAULT_PERIOD(2),
        .DEFAULT_HIGH(1)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef SYNC_RESTART_EN
        .sync_in(sync_in),
`endif
        .ch_en(ch_en),
        .wr_en(wr_en),
        .wr_ch(wr_ch),
        .wr_period(wr_period),
        .wr_high(wr_high),
        .wr_err(wr_err),
        .clk_out(clk_out),
        .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [4:0] exp_clk, input logic [4:0] exp_tick);
        chk5({tag, "_clk"}, clk_out, exp_clk);
        chk5({tag, "_tick"}, tick, exp_tick);
    endtask

    task automatic wr(input logic [2:0] ch, input logic [7:0] p, input logic [7:0] h);
        wr_en     = 1'b1;
        wr_ch     = ch;
        wr_period = p;
        wr_high   = h;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ch_en = '0; wr_en = 1'b0; wr_ch = '0; wr_period = '0; wr_high = '0;
`ifdef SYNC_RESTART_EN
        sync_in = 1'b0;
`endif
        cyc(); cyc();
        chk_out("reset", 5'b0, 5'b0);
        chk1("reset_err", wr_err, 1'b0);

        // Defaults: P=2 H=1 on ch0
        rst = 1'b0; ch_en = 5'b00001;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_out("dflt", (i % 2 == 0) ? 5'b00001 : 5'b0, (i % 2 == 0) ? 5'b00001 : 5'b0);
        end
        rst = 1'b1;
        #1;
        chk_out("async_rst", 5'b0, 5'b0);
        cyc();
        chk_out("held_rst", 5'b0, 5'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_out("restart", (i % 2 == 0) ? 5'b00001 : 5'b0, (i % 2 == 0) ? 5'b00001 : 5'b0);
        end
        ch_en = '0;
        cyc();
        chk_out("dis0", 5'b0, 5'b0);

        // ch1 P=5 H=2 programmed while disabled
        wr(3'd1, 8'd5, 8'd2);
        cyc();
        wr_en = 1'b0;
        chk_out("b_wr", 5'b0, 5'b0);
        chk1("b_err", wr_err, 1'b0);
        ch_en = 5'b00010;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk_out("b_duty", (i % 5 < 2) ? 5'b00010 : 5'b0, (i % 5 == 0) ? 5'b00010 : 5'b0);
        end
        ch_en = '0;
        cyc();
        chk_out("b_midoff", 5'b0, 5'b0);

        // ch2 P=4 H=2, then P=6 H=3 written at cnt=1
        wr(3'd2, 8'd4, 8'd2);
        cyc();
        wr_en = 1'b0;
        ch_en = 5'b00100;
        for (int i = 0; i < 11; i++) begin
            cyc();
            chk_out("c_glitch", (c1_clk[i] != 0) ? 5'b00100 : 5'b0, (c1_tick[i] != 0) ? 5'b00100 : 5'b0);
            if (i == 1) wr(3'd2, 8'd6, 8'd3);
            if (i == 2) wr_en = 1'b0;
        end
        // P=4 H=2 written on the wrap cycle
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk_out("c_onwrap", (c2_clk[i] != 0) ? 5'b00100 : 5'b0, (c2_tick[i] != 0) ? 5'b00100 : 5'b0);
            if (i == 4) wr(3'd2, 8'd4, 8'd2);
            if (i == 5) wr_en = 1'b0;
        end

        // Rejected writes: bad channel, then zero period
        wr(3'd5, 8'd3, 8'd1);
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk1("d_err", wr_err, (i < 2));
            chk_out("d_keep", ((i + 1) % 4 < 2) ? 5'b00100 : 5'b0, ((i + 1) % 4 == 0) ? 5'b00100 : 5'b0);
            if (i == 0) wr(3'd2, 8'd0, 8'd5);
            if (i == 1) wr_en = 1'b0;
        end
        ch_en = '0;
        cyc();
        chk_out("d_off", 5'b0, 5'b0);

        // Edge duties on ch3
        wr(3'd3, 8'd1, 8'd1);
        cyc();
        wr_en = 1'b0;
        ch_en = 5'b01000;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_out("e_p1", 5'b01000, 5'b01000);
        end
        wr(3'd3, 8'd3, 8'd0);
        cyc();
        wr_en = 1'b0;
        chk_out("e_p1_last", 5'b01000, 5'b01000);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk_out("e_h0", 5'b0, (i % 3 == 0) ? 5'b01000 : 5'b0);
        end
        wr(3'd3, 8'd3, 8'd7);
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk_out("e_hbig", (i >= 3) ? 5'b01000 : 5'b0, (i % 3 == 0) ? 5'b01000 : 5'b0);
            if (i == 0) wr_en = 1'b0;
        end
        ch_en = '0;
        cyc();
        chk_out("e_off", 5'b0, 5'b0);

`ifdef SYNC_RESTART_EN
        // Two channels in different phases, then aligned by sync_in
        wr(3'd0, 8'd3, 8'd1);
        cyc();
        wr(3'd1, 8'd5, 8'd2);
        cyc();
        wr_en = 1'b0;
        ch_en = 5'b00001;
        cyc(); cyc();
        ch_en = 5'b00011;
        cyc(); cyc();
        sync_in = 1'b1;
        cyc();
        sync_in = 1'b0;
        chk_out("s_sync", 5'b00011, 5'b00011);
        for (int i = 1; i <= 15; i++) begin
            cyc();
            chk_out("s_align",
                    ((i % 3 < 1) ? 5'b00001 : 5'b0) | ((i % 5 < 2) ? 5'b00010 : 5'b0),
                    ((i % 3 == 0) ? 5'b00001 : 5'b0) | ((i % 5 == 0) ? 5'b00010 : 5'b0));
        end
        ch_en = '0;
        cyc();
        chk_out("s_off", 5'b0, 5'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
